seg_scan_ctrl: RTL and testbench

Time-multiplexing controller for the board's 4-digit common-anode seven-segment display. It sequences the shared 4-bit 4:1 digit selector through four nibble sources, decodes the selected nibble to segments, and drives one anode at a time. Each digit gets one blanking cycle for ghost suppression. Nibbles are snapshotted once per frame, and the block supports per-digit blanking and leading-zero suppression.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg7_hex_decoder.sv | 11 +
 rtl/seg_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared encodings for the seven-segment scan controller: scan states,
// the blank pattern and the active-low hex glyph table.
package seg_pkg;

    typedef enum logic {
        GAP   = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode display scanner with one blanking cycle per digit,
// per-frame input snapshot, per-digit blanking and leading-zero suppression.
//
// state | meaning
// GAP   | one cycle, all anodes off while the digit selector settles
// DRIVE | remaining slot cycles, anode of digit sel_q on
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] dp_in,
    input  logic [3:0] blank_mask,
    input  logic       lz_en,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sel_q, sel_d;
    scan_state_t     state_q, state_d;
    logic [3:0][3:0] snap_nib_q, snap_nib_d;
    logic [3:0]      snap_dp_q, snap_dp_d;
    logic [3:0]      snap_blank_q, snap_blank_d;
    logic            snap_lz_q, snap_lz_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            tick_q, tick_d;

    logic            terminal;
    logic            upper_zero;
    logic            digit_dark;
    logic [6:0]      dec_seg;

    seg7_hex_decoder u_dec (
        .nibble_i (snap_nib_q[sel_q]),
        .seg_o    (dec_seg)
    );

    assign terminal = (cnt_q == CNT_MAX);

    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(sel_q) && snap_nib_q[k] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        digit_dark = snap_blank_q[sel_q] || (snap_lz_q && (sel_q != 2'd0) && upper_zero);
    end

    always_comb begin
        cnt_d        = cnt_q + 1'b1;
        sel_d        = sel_q;
        snap_nib_d   = snap_nib_q;
        snap_dp_d    = snap_dp_q;
        snap_blank_d = snap_blank_q;
        snap_lz_d    = snap_lz_q;
        an_d         = 4'hF;
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;
        tick_d       = 1'b0;
        state_d      = state_q;

        case (state_q)
            GAP:   state_d = DRIVE;
            DRIVE: if (terminal) state_d = GAP;
        endcase

        // Also covers leaving reset, which parks in GAP at terminal count.
        if (terminal) begin
            state_d = GAP;
            cnt_d   = '0;
            sel_d   = sel_q + 2'd1;
            if (sel_d == 2'd0) begin
                snap_nib_d   = {d3, d2, d1, d0};
                snap_dp_d    = dp_in;
                snap_blank_d = blank_mask;
                snap_lz_d    = lz_en;
                tick_d       = 1'b1;
            end
        end

        if (state_d == DRIVE) begin
            an_d = ~(4'b0001 << sel_q);
            if (!digit_dark) begin
                seg_d = dec_seg;
                dp_d  = ~snap_dp_q[sel_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= CNT_MAX;
            sel_q        <= 2'd3;
            state_q      <= GAP;
            snap_nib_q   <= '0;
            snap_dp_q    <= '0;
            snap_blank_q <= '0;
            snap_lz_q    <= 1'b0;
            an_q         <= 4'hF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            state_q      <= state_d;
            snap_nib_q   <= snap_nib_d;
            snap_dp_q    <= snap_dp_d;
            snap_blank_q <= snap_blank_d;
            snap_lz_q    <= snap_lz_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            tick_q       <= tick_d;
        end
    end

    assign sel        = sel_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl at REFRESH_DIV = 4: per-cycle scoreboard against a
// frame-position model, a vector table of display patterns, and corner sequences.
module tb_seg_scan_ctrl;

    localparam int RD = 4;
    localparam int NV = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d0, d1, d2, d3, dp_in, blank_mask;
    logic       lz_en;
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, frame_tick;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .rst        (rst),
        .d0         (d0),
        .d1         (d1),
        .d2         (d2),
        .d3         (d3),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .sel        (sel),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    typedef struct {
        logic [1:0] sel;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    typedef struct {
        logic [15:0]     nib;
        logic [3:0]      dpi;
        logic [3:0]      blk;
        logic            lz;
        logic [3:0][6:0] segs;
        logic [3:0]      dpo;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[NV];
    int   checks   = 0;
    int   failures = 0;

    int          m_pos = -1;
    logic [15:0] m_nib;
    logic [3:0]  m_dpi, m_blk;
    logic        m_lz;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic dark_of(input int k);
        logic z;
        z = 1'b1;
        for (int j = k; j < 4; j++) if (m_nib[j*4 +: 4] != 4'h0) z = 1'b0;
        return m_blk[k] || (m_lz && k != 0 && z);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at time %0t", name, act, req, $time);
        end
    endtask

    // Expected outputs after the coming edge, from the frame position alone.
    task automatic model_edge();
        exp_t e;
        int   k;
        if (rst) begin
            m_pos = -1;
            e = '{2'd3, 4'hF, 7'h7F, 1'b1, 1'b0};
        end else begin
            m_pos = (m_pos + 1) % 16;
            if (m_pos == 0) begin
                m_nib = {d3, d2, d1, d0};
                m_dpi = dp_in;
                m_blk = blank_mask;
                m_lz  = lz_en;
            end
            k = m_pos / 4;
            e = '{2'(k), 4'hF, 7'h7F, 1'b1, (m_pos == 0)};
            if (m_pos % 4 != 0) begin
                e.an[k] = 1'b0;
                if (!dark_of(k)) begin
                    e.seg = ref_seg(m_nib[k*4 +: 4]);
                    e.dp  = ~m_dpi[k];
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        e = exp_q.pop_front();
        chk("sb_sel", {6'b0, sel}, {6'b0, e.sel});
        chk("sb_an", {4'b0, an}, {4'b0, e.an});
        chk("sb_seg", {1'b0, seg}, {1'b0, e.seg});
        chk("sb_dp", {7'b0, dp}, {7'b0, e.dp});
        chk("sb_frame_tick", {7'b0, frame_tick}, {7'b0, e.ft});
    endtask

    task automatic set_inputs(input logic [15:0] nib, input logic [3:0] dpi,
                              input logic [3:0] blk, input logic lz);
        {d3, d2, d1, d0} = nib;
        dp_in      = dpi;
        blank_mask = blk;
        lz_en      = lz;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        set_inputs(v.nib, v.dpi, v.blk, v.lz);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i % 4 == 2) begin
                k = i / 4;
                chk("vec_seg", {1'b0, seg}, {1'b0, v.segs[k]});
                chk("vec_dp", {7'b0, dp}, {7'b0, v.dpo[k]});
            end
        end
    endtask

    initial begin
        int last;
        int pulses;

        vecs[0] = '{16'h1234, 4'h0, 4'h0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
        vecs[1] = '{16'h0007, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'hF};
        vecs[2] = '{16'h0000, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
        vecs[3] = '{16'h0000, 4'h0, 4'h0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF};
        vecs[4] = '{16'h8AF0, 4'b0100, 4'b0010, 1'b0, {7'h00, 7'h08, 7'h7F, 7'h40}, 4'b1011};
        vecs[5] = '{16'h0500, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h12, 7'h40, 7'h40}, 4'hF};
        vecs[6] = '{16'hCDEB, 4'hF, 4'h0, 1'b0, {7'h46, 7'h21, 7'h06, 7'h03}, 4'h0};
        vecs[7] = '{16'h9999, 4'hF, 4'hF, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF};

        rst = 1'b1;
        set_inputs(16'h0000, 4'h0, 4'h0, 1'b0);
        tick();
        tick();
        chk("reset_an", {4'b0, an}, 8'h0F);
        chk("reset_sel", {6'b0, sel}, 8'h03);

        for (int v = 0; v < NV; v++) run_vec(vecs[v]);

        // Mid-frame nibble changes only appear from the next frame.
        set_inputs(16'h1234, 4'h0, 4'h0, 1'b0);
        do_reset();
        for (int i = 0; i < 48; i++) begin
            tick();
            if (i == 9)  d1 = 4'h9;
            if (i == 17) d2 = 4'h7;
            if (i == 22) chk("newframe_d1", {1'b0, seg}, 8'h10);
            if (i == 26) chk("notear_d2", {1'b0, seg}, 8'h24);
            if (i == 42) chk("newframe_d2", {1'b0, seg}, 8'h78);
        end

        set_inputs(16'h1234, 4'h0, 4'h0, 1'b0);
        do_reset();
        last   = -1;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (frame_tick) begin
                if (last >= 0) chk("ft_period", 8'(i - last), 8'd16);
                else           chk("ft_first", 8'(i), 8'd0);
                last = i;
                pulses++;
            end
        end
        chk("ft_count", 8'(pulses), 8'd4);

        do_reset();
        for (int i = 0; i < 10; i++) tick();
        chk("pre_rst_an", {4'b0, an}, 8'h0B);
        rst = 1'b1;
        tick();
        chk("mid_rst_an", {4'b0, an}, 8'h0F);
        chk("mid_rst_sel", {6'b0, sel}, 8'h03);
        chk("mid_rst_ft", {7'b0, frame_tick}, 8'h00);
        rst = 1'b0;
        tick();
        chk("post_rst_sel", {6'b0, sel}, 8'h00);
        chk("post_rst_ft", {7'b0, frame_tick}, 8'h01);
        chk("post_rst_an", {4'b0, an}, 8'h0F);
        tick();
        chk("post_rst_drive_an", {4'b0, an}, 8'h0E);
        chk("post_rst_drive_seg", {1'b0, seg}, 8'h19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
